// File: rtl/avalon_pulse_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : avalon_pulse_pio_pkg
// Brief   : Register map and bus-width constants for avalon_pulse_pio.
// Revision: 1.0 - initial release
// ============================================================================
package avalon_pulse_pio_pkg;

  // Avalon-MM bus geometry
  localparam int BUS_W  = 32;
  localparam int ADDR_W = 3;

  // Register word addresses
  localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PULSE     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_EVENT     = 3'd7;

  // Legal parameter ranges
  localparam int WIDTH_MAX = 32;
  localparam int LEN_W_MAX = 16;

endpackage : avalon_pulse_pio_pkg
`default_nettype wire

// File: rtl/pulse_pio_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : pulse_pio_bit_timer
// Brief   : Per-bit pulse down-counter. A load replaces the count (reload wins
//           over decrement); busy while nonzero; done flags the 1->0 step.
// Revision: 1.0 - initial release
// ============================================================================
module pulse_pio_bit_timer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done
);

  logic [LEN_W-1:0] r_cnt;

  // Load has priority so a retrigger extends the pulse without a gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);
  // Completion only on a natural decrement to zero, never on a reload
  assign o_done = (r_cnt == LEN_W'(1)) && !i_load;

endmodule : pulse_pio_bit_timer
`default_nettype wire

// File: rtl/avalon_pulse_pio.sv
`default_nettype none
// ============================================================================
// Module  : avalon_pulse_pio
// Brief   : Avalon-MM PIO with a level register and per-bit one-shot pulses.
//           Optional interrupt logic enabled by macro AVALON_PULSE_PIO_IRQ_EN
//           (IRQ_MASK at addr 5, sticky EVENT at addr 7).
// Revision: 1.0 - initial release
// ============================================================================
module avalon_pulse_pio
  import avalon_pulse_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LEN_W     = 8,
  parameter int LEN_RESET = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BUS_W-1:0]  writedata,
  output logic [BUS_W-1:0]  readdata,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  logic [WIDTH-1:0] r_data;
  logic [LEN_W-1:0] r_len;
  logic [WIDTH-1:0] w_wd;
  logic             w_wr;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_busy;
  logic [WIDTH-1:0] w_done;
  logic             w_unused;

  assign w_wr   = chipselect && !write_n;
  assign w_wd   = writedata[WIDTH-1:0];
  assign w_load = (w_wr && (address == ADDR_PULSE)) ? w_wd : '0;

  // Level register with whole-word write plus set/clear aliases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_wr) begin
      if (address == ADDR_DATA)          r_data <= w_wd;
      else if (address == ADDR_OUTSET)   r_data <= r_data | w_wd;
      else if (address == ADDR_OUTCLEAR) r_data <= r_data & ~w_wd;
    end
  end

  // Pulse length; running counters keep the value they were loaded with
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len <= LEN_W'(LEN_RESET);
    end else if (w_wr && (address == ADDR_PULSE_LEN)) begin
      r_len <= writedata[LEN_W-1:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pulse_pio_bit_timer #(.LEN_W(LEN_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load[gi]),
        .i_len  (r_len),
        .o_busy (w_busy[gi]),
        .o_done (w_done[gi])
      );
    end
  endgenerate

  // Pure OR of flop outputs keeps bus inputs off the pin path
  assign out_port = r_data | w_busy;

`ifdef AVALON_PULSE_PIO_IRQ_EN
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_event;

  // Interrupt mask and sticky completion events; a new event beats W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask  <= '0;
      r_event <= '0;
    end else begin
      if (w_wr && (address == ADDR_IRQ_MASK)) r_mask <= w_wd;
      if (w_wr && (address == ADDR_EVENT))    r_event <= (r_event & ~w_wd) | w_done;
      else                                    r_event <= r_event | w_done;
    end
  end

  assign irq      = |(r_event & r_mask);
  assign w_unused = &{1'b0, writedata};
`else
  assign irq      = 1'b0;
  assign w_unused = &{1'b0, writedata, w_done};
`endif

  // Zero-latency read mux, zero-extended to the bus width
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0] = r_data;
      ADDR_PULSE_LEN: readdata[LEN_W-1:0] = r_len;
      ADDR_PULSE:     readdata[WIDTH-1:0] = w_busy;
`ifdef AVALON_PULSE_PIO_IRQ_EN
      ADDR_IRQ_MASK:  readdata[WIDTH-1:0] = r_mask;
      ADDR_EVENT:     readdata[WIDTH-1:0] = r_event;
`endif
      default:        readdata = '0;
    endcase
  end

endmodule : avalon_pulse_pio
`default_nettype wire
